// File: rtl/pulse_period_meter.sv
// rtl/pulse_period_meter.sv - edge-to-edge period meter with timeout, valid/ready result and overrun flag
module pulse_period_meter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             pulse_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             timeout,
    output logic             overrun
);

    typedef enum logic [1:0] {IDLE, ARMED, MEASURE, TMO} state_t;

    localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic             pulse_q;
    logic             pulse_edge;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] cnt_nxt;
    logic             capture;
    logic             flush;

    assign pulse_edge = pulse_in & ~pulse_q;
    assign cnt_inc    = cnt + WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ARMED;
                ARMED:   if (pulse_edge) state_nxt = MEASURE;
                MEASURE: if (!pulse_edge && cnt == LAST_CNT) state_nxt = TMO;
                TMO:     if (pulse_edge) state_nxt = MEASURE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // An edge restarts the count from zero so the next capture reads cnt+1 = edge distance.
    always_comb begin
        capture = 1'b0;
        flush   = !enable;
        cnt_nxt = cnt;
        case (state)
            IDLE:        cnt_nxt = '0;
            ARMED, TMO:  if (pulse_edge) cnt_nxt = '0;
            MEASURE: begin
                capture = pulse_edge;
                cnt_nxt = pulse_edge ? '0 : cnt_inc;
            end
            default:     cnt_nxt = '0;
        endcase
        if (flush) begin
            capture = 1'b0;
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q      <= 1'b0;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            pulse_q <= pulse_in;
            cnt     <= cnt_nxt;
            timeout <= (state_nxt == TMO);
            if (flush) begin
                period_valid <= 1'b0;
                overrun      <= 1'b0;
            end else if (capture) begin
                // A full, unconsumed buffer keeps the old value; the new one is dropped.
                if (!period_valid || period_ready) begin
                    period       <= cnt_inc;
                    period_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (period_ready) begin
                period_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_period_meter.sv
// tb/tb_pulse_period_meter.sv - scoreboard testbench for pulse_period_meter
module tb_pulse_period_meter;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 20;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             pulse_in = 1'b0;
    logic [WIDTH-1:0] period;
    logic             period_valid;
    logic             period_ready = 1'b1;
    logic             timeout;
    logic             overrun;

    typedef struct {
        int p;
        int c;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    pulse_period_meter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .pulse_in     (pulse_in),
        .period       (period),
        .period_valid (period_valid),
        .period_ready (period_ready),
        .timeout      (timeout),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int p, input int c);
        exp_t e;
        e.p = p;
        e.c = c;
        q.push_back(e);
    endtask

    task automatic pulse_once();
        pulse_in = 1'b1;
        tick();
        pulse_in = 1'b0;
    endtask

    // Monitor: every accepted result must match the oldest expectation.
    always @(negedge clk) begin
        if (period_valid === 1'b1 && period_ready === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_period: got %0d expected none (cycle %0d)", period, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (int'(period) != e.p || (e.c >= 0 && cyc != e.c)) begin
                    failures++;
                    $display("FAIL period_sb: got %0d at cycle %0d expected %0d at cycle %0d",
                             period, cyc, e.p, e.c);
                end
            end
        end
    end

    initial begin
        int c0;
        // Reset values
        tick();
        tick();
        rst = 1'b0;
        chk("rst_period", int'(period), 0);
        chk("rst_valid", int'(period_valid), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_overrun", int'(overrun), 0);

        // Pulses every 10 cycles, consumer always ready
        enable = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) push(10, cyc + 1);
            pulse_once();
            repeat (9) tick();
        end

        // Disable mid-measurement, then a 30-cycle level: one edge, then timeout
        enable = 1'b0;
        tick();
        chk("dis_valid", int'(period_valid), 0);
        chk("dis_timeout", int'(timeout), 0);
        enable = 1'b1;
        tick();
        c0 = cyc;
        pulse_in = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            chk("level_timeout", int'(timeout), (k >= 21) ? 1 : 0);
        end
        pulse_in = 1'b0;
        tick();
        chk("tmo_held", int'(timeout), 1);

        // Edge out of timeout clears it; the following edge measures 12
        pulse_once();
        chk("tmo_clear", int'(timeout), 0);
        repeat (11) tick();
        push(12, cyc + 1);
        pulse_once();
        repeat (24) tick();
        chk("meas_timeout", int'(timeout), 1);
        chk("meas_tmo_valid", int'(period_valid), 0);
        pulse_once();
        chk("tmo_clear2", int'(timeout), 0);
        repeat (7) tick();
        push(8, cyc + 1);
        pulse_once();

        // Consumer stalled, pulses every 5: period 5 held, overrun on the 3rd edge
        tick();
        period_ready = 1'b0;
        repeat (3) tick();
        push(5, -1);
        pulse_once();
        repeat (4) tick();
        chk("ovr_before", int'(overrun), 0);
        pulse_once();
        chk("ovr_set", int'(overrun), 1);
        chk("ovr_valid", int'(period_valid), 1);
        chk("ovr_period", int'(period), 5);
        repeat (4) tick();
        pulse_once();
        chk("ovr_period2", int'(period), 5);
        tick();
        period_ready = 1'b1;
        tick();
        chk("drain_valid", int'(period_valid), 0);
        chk("ovr_sticky", int'(overrun), 1);

        // Capture coinciding with acceptance: 7 replaced by 9, no overrun
        enable = 1'b0;
        tick();
        chk("idle_overrun", int'(overrun), 0);
        enable = 1'b1;
        tick();
        period_ready = 1'b0;
        pulse_once();
        repeat (6) tick();
        push(7, -1);
        pulse_once();
        chk("p7_valid", int'(period_valid), 1);
        chk("p7_period", int'(period), 7);
        repeat (8) tick();
        period_ready = 1'b1;
        push(9, cyc + 1);
        pulse_once();
        chk("p9_period", int'(period), 9);
        chk("p9_valid", int'(period_valid), 1);
        chk("p9_overrun", int'(overrun), 0);
        tick();
        chk("p9_drained", int'(period_valid), 0);

        // Reset mid-measurement; first edge after recovery only arms
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_period", int'(period), 0);
        chk("mrst_valid", int'(period_valid), 0);
        chk("mrst_timeout", int'(timeout), 0);
        chk("mrst_overrun", int'(overrun), 0);
        tick();
        pulse_once();
        repeat (4) tick();
        push(5, cyc + 1);
        pulse_once();

        // Disable mid-measurement with a pending result and overrun set
        tick();
        period_ready = 1'b0;
        repeat (3) tick();
        pulse_once();
        repeat (4) tick();
        pulse_once();
        chk("dis_ovr_set", int'(overrun), 1);
        enable = 1'b0;
        tick();
        chk("dis2_valid", int'(period_valid), 0);
        chk("dis2_overrun", int'(overrun), 0);
        chk("dis2_timeout", int'(timeout), 0);
        chk("dis2_period_kept", int'(period), 5);
        period_ready = 1'b1;
        enable = 1'b1;
        tick();
        pulse_once();
        repeat (3) tick();
        chk("rearm_no_period", int'(period_valid), 0);
        repeat (2) tick();
        push(6, cyc + 1);
        pulse_once();
        repeat (3) tick();

        chk("sb_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_period_meter.md
PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

Interface
REQ-001 SHALL have parameter WIDTH, 16, width of the period counter and result.
REQ-002 SHALL have parameter TIMEOUT, 1000, cycles without an edge before timeout; legal range 2..2^WIDTH-1.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  measurement enable; low forces IDLE.
REQ-006 SHALL have port pulse_in  input  1  synchronous pulse or level stream to be timed, e.g. a cycle-counter result output.
REQ-007 SHALL have port period  output  WIDTH  last measured edge-to-edge interval in clk cycles.
REQ-008 SHALL have port period_valid  output  1  period holds an unconsumed measurement.
REQ-009 SHALL have port period_ready  input  1  consumer accepts period when high with period_valid.
REQ-010 SHALL have port timeout  output  1  no edge seen within TIMEOUT cycles.
REQ-011 SHALL have port overrun  output  1  sticky; a measurement was dropped because the buffer was full.

Function
REQ-012 SHALL register pulse_in into pulse_q; an edge is pulse_in=1 and pulse_q=0 in the same cycle.
REQ-013 SHALL implement FSM states IDLE, ARMED, MEASURE and TMO.
REQ-014 IDLE: enable=1 -> ARMED next cycle. All other states: enable=0 -> IDLE next cycle, overriding everything else.
REQ-015 ARMED: edge -> MEASURE with cnt=0; no period is produced.
REQ-016 MEASURE, cycle without edge: cnt increments by 1.
REQ-017 MEASURE, edge: capture period=cnt+1, set cnt=0, stay in MEASURE.
REQ-018 Period definition: edges at cycles t0 and t1 SHALL yield period=t1-t0. Continuous pulse_in=1 produces one edge only.
REQ-019 MEASURE: when cnt+1 reaches TIMEOUT with no edge -> TMO; timeout=1 from the cycle TMO is entered; no period is produced.
REQ-020 TMO: edge -> MEASURE with cnt=0 and timeout=0 next cycle; enable=0 -> IDLE with timeout=0.
REQ-021 cnt SHALL never wrap; TIMEOUT <= 2^WIDTH-1 guarantees the timeout fires before saturation.
REQ-022 Capture: period and period_valid=1 SHALL be registered one cycle after the edge cycle (latency 1).
REQ-023 Handshake: period_valid=1 and period_ready=1 in a cycle consumes the data; period_valid falls next cycle unless a new capture occurs in that same cycle.
REQ-024 A capture with period_valid=1 and period_ready=1 in the same cycle SHALL load the new period with period_valid remaining 1; no overrun.
REQ-025 A capture with period_valid=1 and period_ready=0 SHALL drop the new value, keep the old period, and set overrun=1.
REQ-026 period_valid SHALL NOT depend combinationally on period_ready. period SHALL be stable while period_valid=1 and period_ready=0.
REQ-027 Entering IDLE SHALL clear cnt, period_valid, timeout and overrun; period keeps its last value.

Reset
REQ-028 rst=1 at a clock edge SHALL force state IDLE, cnt=0, pulse_q=0, period=0, period_valid=0, timeout=0 and overrun=0, overriding all other inputs.
REQ-029 rst asserted mid-measurement SHALL discard any partial count. The first edge after reset and enable only arms the block.

Verification
REQ-030 Reset, then enable=1, 1-cycle pulses every 10 cycles, period_ready=1 -> first pulse produces no output; each later pulse produces period=10 with period_valid high 1 cycle, edge+1 latency.
REQ-031 pulse_in held high for 30 cycles after arming -> a single edge only; timeout=1 when cnt+1 reaches TIMEOUT (TIMEOUT=20 in this test).
REQ-032 period_ready=0, pulses every 5 cycles -> period=5 held; overrun=1 after the 3rd edge; raise period_ready -> valid drops next cycle.
REQ-033 Capture coinciding with period_ready=1 while valid, period changing 7 to 9 -> period=9, valid stays 1, overrun stays 0.
REQ-034 TIMEOUT=20, no edge for 25 cycles while in MEASURE -> timeout=1 and no period; next edge clears timeout, the edge after it reports the correct period.
REQ-035 rst pulse and, separately, enable=0 mid-measurement -> all flags 0 next cycle; the first edge after recovery produces no period.
